// File: rtl/wb_multiport_bankram.sv
// Multi-port, multi-bank pipelined Wishbone word RAM.
// Each bank has its own round-robin arbiter, so masters that target different banks
// proceed in parallel. Each bank does at most one access per cycle. A losing master
// sees stall until it is granted. Reads and writes both ack one cycle after acceptance.
module wb_multiport_bankram #(
   parameter int unsigned NUM_PORTS  = 3,
   parameter int unsigned NUM_BANKS  = 2,
   parameter int unsigned BANK_DEPTH = 1024,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = $clog2(NUM_BANKS) + $clog2(BANK_DEPTH)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NUM_PORTS-1:0]            wb_stb_i,
   input  logic [NUM_PORTS-1:0]            wb_we_i,
   input  logic [NUM_PORTS*DATA_W/8-1:0]   wb_sel_i,
   input  logic [NUM_PORTS*ADDR_W-1:0]     wb_addr_i,
   input  logic [NUM_PORTS*DATA_W-1:0]     wb_data_i,
   output logic [NUM_PORTS*DATA_W-1:0]     wb_data_o,
   output logic [NUM_PORTS-1:0]            wb_ack_o,
   output logic [NUM_PORTS-1:0]            wb_stall_o
);

   localparam int unsigned BANK_W = $clog2(NUM_BANKS);
   localparam int unsigned ROW_W  = ADDR_W - BANK_W;
   localparam int unsigned PTR_W  = $clog2(NUM_PORTS);
   localparam int unsigned SEL_W  = DATA_W / 8;

   // Per-port address decode
   logic [BANK_W-1:0]    port_bank [NUM_PORTS];
   logic [ROW_W-1:0]     port_row  [NUM_PORTS];

   // Per-bank arbitration result and the granted request
   logic [NUM_BANKS-1:0] gnt_vld;
   logic [PTR_W-1:0]     gnt_port   [NUM_BANKS];
   logic [NUM_BANKS-1:0] bank_we;
   logic [ROW_W-1:0]     bank_row   [NUM_BANKS];
   logic [DATA_W-1:0]    bank_wdata [NUM_BANKS];
   logic [SEL_W-1:0]     bank_sel   [NUM_BANKS];

   // State
   logic [PTR_W-1:0]     prio_ptr   [NUM_BANKS];
   logic [NUM_PORTS-1:0] ack;
   logic [NUM_PORTS-1:0] ack_rd;
   logic [BANK_W-1:0]    rd_bank    [NUM_PORTS];
   logic [DATA_W-1:0]    data_hold  [NUM_PORTS];
   logic [NUM_PORTS-1:0] stall;
   logic [NUM_PORTS-1:0] accept;

   // Storage, not reset
   logic [DATA_W-1:0]    mem        [NUM_BANKS][BANK_DEPTH];
   logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

   // Split each port's word address into bank select and row
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_bank[p] = wb_addr_i[p*ADDR_W + ROW_W +: BANK_W];
         port_row[p]  = wb_addr_i[p*ADDR_W +: ROW_W];
      end
   end

   // Round-robin search per bank, starting at that bank's priority pointer
   always_comb begin
      int unsigned idx;
      idx = 0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         gnt_vld[b]  = 1'b0;
         gnt_port[b] = '0;
         for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            idx = int'(prio_ptr[b]) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!gnt_vld[b] && wb_stb_i[idx] && (port_bank[idx] == BANK_W'(b))) begin
               gnt_vld[b]  = 1'b1;
               gnt_port[b] = PTR_W'(idx);
            end
         end
      end
   end

   // Route the granted port's request to its bank
   always_comb begin
      int gi;
      gi = 0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         gi            = int'(gnt_port[b]);
         bank_we[b]    = wb_we_i[gi];
         bank_row[b]   = port_row[gi];
         bank_wdata[b] = wb_data_i[gi*DATA_W +: DATA_W];
         bank_sel[b]   = wb_sel_i[gi*SEL_W +: SEL_W];
      end
   end

   // A requesting port stalls unless it is the winner for its bank
   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         stall[p]  = wb_stb_i[p] && (gnt_port[port_bank[p]] != PTR_W'(p));
         accept[p] = wb_stb_i[p] && !stall[p];
      end
   end

   assign wb_stall_o = stall;
   assign wb_ack_o   = ack;

   // Arbiter pointers, acks and per-port read-data holding registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int b = 0; b < NUM_BANKS; b++) prio_ptr[b] <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            rd_bank[p]   <= '0;
            data_hold[p] <= '0;
         end
         ack    <= '0;
         ack_rd <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (gnt_vld[b]) begin
               prio_ptr[b] <= (gnt_port[b] == PTR_W'(NUM_PORTS - 1)) ? '0
                                                                      : gnt_port[b] + 1'b1;
            end
         end
         for (int p = 0; p < NUM_PORTS; p++) begin
            // Capture the read word one cycle after it was fetched so data_o holds it
            if (ack_rd[p]) data_hold[p] <= bank_rdata[rd_bank[p]];
            if (accept[p]) rd_bank[p] <= port_bank[p];
         end
         ack    <= accept;
         ack_rd <= accept & ~wb_we_i;
      end
   end

   // Single-port bank storage: byte-masked write or registered read of the granted row
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (gnt_vld[b]) begin
            if (bank_we[b]) begin
               for (int i = 0; i < SEL_W; i++) begin
                  if (bank_sel[b][i]) mem[b][bank_row[b]][8*i +: 8] <= bank_wdata[b][8*i +: 8];
               end
            end else begin
               bank_rdata[b] <= mem[b][bank_row[b]];
            end
         end
      end
   end

   // Fresh bank data in the ack cycle, otherwise the held value
   always_comb begin
      wb_data_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         wb_data_o[p*DATA_W +: DATA_W] = ack_rd[p] ? bank_rdata[rd_bank[p]] : data_hold[p];
      end
   end

endmodule

// File: tb/tb_wb_multiport_bankram.sv
// Self-checking bench for wb_multiport_bankram: directed scenarios plus randomized
// traffic, all compared against a word-level reference model of the RAM and arbiters.
module tb_wb_multiport_bankram;

   localparam int NP = 3;
   localparam int NB = 2;
   localparam int DW = 32;
   localparam int AW = 11;
   localparam int SW = DW / 8;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic [NP-1:0]   wb_stb_i = '0;
   logic [NP-1:0]   wb_we_i = '0;
   logic [NP*SW-1:0] wb_sel_i = '0;
   logic [NP*AW-1:0] wb_addr_i = '0;
   logic [NP*DW-1:0] wb_data_i = '0;
   logic [NP*DW-1:0] wb_data_o;
   logic [NP-1:0]   wb_ack_o;
   logic [NP-1:0]   wb_stall_o;

   wb_multiport_bankram dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wb_stb_i   (wb_stb_i),
      .wb_we_i    (wb_we_i),
      .wb_sel_i   (wb_sel_i),
      .wb_addr_i  (wb_addr_i),
      .wb_data_i  (wb_data_i),
      .wb_data_o  (wb_data_o),
      .wb_ack_o   (wb_ack_o),
      .wb_stall_o (wb_stall_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model state
   logic [DW-1:0] mmem [2**AW];
   bit            mvld [2**AW];
   int            ptr [NB];
   bit            exp_ack [NP];
   logic [DW-1:0] exp_data [NP];
   bit            exp_dvld [NP];
   bit            last_stall [NP];
   int            ack_cnt [NP];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int bank_of(input logic [AW-1:0] a);
      return int'(a >> (AW - 1));
   endfunction

   task automatic set_port(input int p, input bit stb, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] sel);
      wb_stb_i[p]             = stb;
      wb_we_i[p]              = we;
      wb_addr_i[p*AW +: AW]   = a;
      wb_data_i[p*DW +: DW]   = d;
      wb_sel_i[p*SW +: SW]    = sel;
   endtask

   task automatic idle_all();
      for (int p = 0; p < NP; p++) set_port(p, 1'b0, 1'b0, '0, '0, '0);
   endtask

   function automatic logic [DW-1:0] port_data(input int p);
      return wb_data_o[p*DW +: DW];
   endfunction

   // One bus cycle: check stalls before the edge, update model at the edge, check after
   task automatic step();
      int gnt [NB];
      bit acc [NP];
      bit st;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      #1;
      for (int b = 0; b < NB; b++) begin
         gnt[b] = -1;
         for (int k = 0; k < NP; k++) begin
            int idx;
            idx = (ptr[b] + k) % NP;
            if (gnt[b] < 0 && wb_stb_i[idx] && bank_of(wb_addr_i[idx*AW +: AW]) == b) gnt[b] = idx;
         end
      end
      for (int p = 0; p < NP; p++) begin
         st = wb_stb_i[p] && (gnt[bank_of(wb_addr_i[p*AW +: AW])] != p);
         acc[p] = wb_stb_i[p] && !st;
         last_stall[p] = st;
         check_eq($sformatf("stall[%0d]", p), 64'(wb_stall_o[p]), 64'(st));
      end
      @(posedge clk_i);
      for (int p = 0; p < NP; p++) begin
         a = wb_addr_i[p*AW +: AW];
         d = wb_data_i[p*DW +: DW];
         s = wb_sel_i[p*SW +: SW];
         exp_ack[p] = acc[p];
         if (acc[p]) begin
            if (wb_we_i[p]) begin
               for (int i = 0; i < SW; i++) if (s[i]) mmem[a][8*i +: 8] = d[8*i +: 8];
               if (s == '1) mvld[a] = 1'b1;
            end else begin
               exp_data[p] = mmem[a];
               exp_dvld[p] = mvld[a];
            end
         end
      end
      for (int b = 0; b < NB; b++) if (gnt[b] >= 0) ptr[b] = (gnt[b] + 1) % NP;
      #1;
      for (int p = 0; p < NP; p++) begin
         check_eq($sformatf("ack[%0d]", p), 64'(wb_ack_o[p]), 64'(exp_ack[p]));
         if (wb_ack_o[p]) ack_cnt[p]++;
         if (exp_dvld[p]) check_eq($sformatf("data[%0d]", p), 64'(port_data(p)), 64'(exp_data[p]));
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < NB; b++) ptr[b] = 0;
      for (int p = 0; p < NP; p++) begin
         exp_ack[p]  = 1'b0;
         exp_data[p] = '0;
         exp_dvld[p] = 1'b1;
         last_stall[p] = 1'b0;
      end
   endtask

   task automatic do_reset();
      idle_all();
      rst_ni = 1'b0;
      #1;
      check_eq("rst_ack", 64'(wb_ack_o), 64'(0));
      check_eq("rst_data", 64'(wb_data_o[63:0]) | 64'(wb_data_o[NP*DW-1:64]), 64'(0));
      model_reset();
      repeat (2) @(posedge clk_i);
      #3 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 2**AW; i++) begin
         mmem[i] = '0;
         mvld[i] = 1'b0;
      end
      for (int p = 0; p < NP; p++) ack_cnt[p] = 0;
      do_reset();

      // Parallel writes to different banks, then readback
      set_port(0, 1, 1, 11'h004, 32'hAAAA_BBBB, 4'hF);
      set_port(1, 1, 1, 11'h408, 32'hCCCC_DDDD, 4'hF);
      step();
      check_eq("par_wr_ack", 64'(wb_ack_o), 64'(3'b011));
      set_port(0, 1, 0, 11'h004, '0, '0);
      set_port(1, 1, 0, 11'h408, '0, '0);
      step();
      check_eq("par_rd0", 64'(port_data(0)), 64'(32'hAAAA_BBBB));
      check_eq("par_rd1", 64'(port_data(1)), 64'(32'hCCCC_DDDD));
      idle_all();

      // Same-bank conflict right after reset: P0 first, P1 one cycle later
      do_reset();
      set_port(0, 1, 1, 11'h004, 32'h1111_2222, 4'hF);
      set_port(1, 1, 1, 11'h008, 32'h3333_4444, 4'hF);
      step();
      check_eq("conf_ack0", 64'(wb_ack_o), 64'(3'b001));
      set_port(0, 0, 0, '0, '0, '0);
      step();
      check_eq("conf_ack1", 64'(wb_ack_o), 64'(3'b010));
      set_port(0, 1, 0, 11'h004, '0, '0);
      set_port(1, 1, 0, 11'h008, '0, '0);
      step();
      while (last_stall[1]) begin
         set_port(0, 0, 0, '0, '0, '0);
         step();
      end
      idle_all();
      step();
      check_eq("conf_rd0", 64'(port_data(0)), 64'(32'h1111_2222));
      check_eq("conf_rd1", 64'(port_data(1)), 64'(32'h3333_4444));

      // Byte enables
      set_port(2, 1, 1, 11'h010, 32'hFFFF_FFFF, 4'hF);
      step();
      set_port(2, 1, 1, 11'h010, 32'h1234_5678, 4'b0101);
      step();
      set_port(2, 1, 0, 11'h010, '0, '0);
      step();
      check_eq("byte_en", 64'(port_data(2)), 64'(32'hFF34_FF78));
      idle_all();

      // Round-robin fairness: all three read bank 0 for 9 cycles
      do_reset();
      for (int p = 0; p < NP; p++) ack_cnt[p] = 0;
      set_port(0, 1, 0, 11'h004, '0, '0);
      set_port(1, 1, 0, 11'h008, '0, '0);
      set_port(2, 1, 0, 11'h010, '0, '0);
      for (int c = 0; c < 9; c++) begin
         step();
         check_eq($sformatf("rr_order%0d", c), 64'(wb_ack_o), 64'(3'b001 << (c % 3)));
      end
      for (int p = 0; p < NP; p++) check_eq($sformatf("rr_cnt[%0d]", p), 64'(ack_cnt[p]), 64'(3));
      idle_all();
      step();

      // Reset between an accepted read and its ack
      set_port(0, 1, 0, 11'h004, '0, '0);
      #1;
      @(posedge clk_i);
      #1;
      idle_all();
      rst_ni = 1'b0;
      #1;
      check_eq("midrst_ack", 64'(wb_ack_o), 64'(0));
      check_eq("midrst_data0", 64'(port_data(0)), 64'(0));
      check_eq("midrst_data2", 64'(port_data(2)), 64'(0));
      model_reset();
      repeat (2) @(posedge clk_i);
      #3 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      set_port(0, 1, 0, 11'h004, '0, '0);
      step();
      check_eq("midrst_rd", 64'(port_data(0)), 64'(32'h1111_2222));
      idle_all();

      // Pipelined throughput on P2, bank 1
      for (int i = 0; i < 4; i++) begin
         set_port(2, 1, 1, 11'(11'h400 + i), 32'hBEEF_0000 + 32'(i * 17), 4'hF);
         step();
      end
      for (int p = 0; p < NP; p++) ack_cnt[p] = 0;
      for (int i = 0; i < 4; i++) begin
         set_port(2, 1, 0, 11'(11'h400 + i), '0, '0);
         step();
         check_eq($sformatf("tput_rd%0d", i), 64'(port_data(2)), 64'(32'hBEEF_0000 + 32'(i * 17)));
      end
      check_eq("tput_cnt", 64'(ack_cnt[2]), 64'(4));
      idle_all();
      step();

      // Randomized traffic; stalled masters hold their request
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NP; p++) begin
            if (!last_stall[p]) begin
               logic [AW-1:0] a;
               a = {1'($urandom_range(0, 1)), 10'($urandom_range(0, 15))};
               set_port(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom,
                        ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom));
            end
         end
         step();
      end
      idle_all();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wb_multiport_bankram.md
# wb_multiport_bankram

Parametrised multi-port, multi-bank Wishbone (pipelined) word RAM. It is the successor to the two-port/two-bank RAM and scales to any number of masters and banks. Each bank carries its own round-robin arbiter, so masters targeting different banks proceed in parallel. A master that loses arbitration for a bank sees stall until it is granted. The block sits between the core-side Wishbone masters (CPU, DMA, debug) and on-chip SRAM storage.

## Interface
Parameters:
- NUM_PORTS, 3, number of Wishbone slave ports (≥2)
- NUM_BANKS, 2, number of independent banks (power of two, ≥2)
- BANK_DEPTH, 1024, words per bank (power of two)
- DATA_W, 32, word width (multiple of 8)
- ADDR_W, derived = log2(NUM_BANKS)+log2(BANK_DEPTH), word address width (11 at defaults)

Ports (all per-port signals are flattened, with port p occupying slice p):
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- wb_stb_i  in  NUM_PORTS  request strobe per port
- wb_we_i  in  NUM_PORTS  1 = write, 0 = read
- wb_sel_i  in  NUM_PORTS*DATA_W/8  byte enables (writes only)
- wb_addr_i  in  NUM_PORTS*ADDR_W  word address; the top log2(NUM_BANKS) bits select the bank
- wb_data_i  in  NUM_PORTS*DATA_W  write data
- wb_data_o  out  NUM_PORTS*DATA_W  read data
- wb_ack_o  out  NUM_PORTS  transfer complete
- wb_stall_o  out  NUM_PORTS  request not accepted this cycle

## Operation
- Bank select: bank = addr[ADDR_W-1 -: log2(NUM_BANKS)]; the row is the remaining low bits.
- Per bank, each cycle:
  - The request set is {p : stb[p] && bank(p)==b}.
  - Exactly one request is granted, chosen by round-robin starting at prio_ptr[b].
- Grant rules:
  - A granted port has stall=0 and is accepted.
  - Every other requesting port for that bank has stall=1.
  - A non-requesting port always has stall=0.
- Pointer update: after a grant to port p, prio_ptr[b] ← (p+1) mod NUM_PORTS. A bank with no request keeps its pointer.
- Accepted write: bytes with sel=1 are written at the row; bytes with sel=0 are unchanged.
- Accepted read: the row contents are registered into data_o[p].
- data_o[p] holds its last read value until the next accepted read on port p. Writes do not alter data_o.
- A master holds stb/we/addr/data/sel stable while stall=1 (Wishbone pipelined rules).
- Memory is not reset; its contents are undefined until written.
- Only one access per bank per cycle, so no same-bank read/write hazard exists.

## Timing
- stall_o is combinational from stb_i, addr_i and prio_ptr, in the same cycle as the request.
- ack_o[p] is asserted for exactly one cycle, in the cycle after acceptance (stb && !stall at the clock edge). Latency is 1 for both reads and writes.
- A read's data_o is valid in the same cycle as its ack.
- Back-to-back accepted requests on one port produce back-to-back acks; throughput is 1/cycle/port when uncontended.
- Under full contention of K ports on one bank, each port is accepted once every K cycles, in round-robin order.
- Read-after-write to the same address, issued in the next cycle, returns the new data.
- Reset (rst_ni=0, asynchronous):
  - ack_o=0 and data_o=0 for all ports.
  - prio_ptr=0 for all banks.
  - An in-flight ack is dropped; memory contents are retained.
- stall_o during reset follows the combinational rule with prio_ptr=0.

## Test plan
- Parallel, different banks:
  - Stimulus: P0 writes 0x004←AAAA_BBBB and P1 writes 0x408←CCCC_DDDD in the same cycle.
  - Required: both stall=0, both acks next cycle; readback returns AAAA_BBBB and CCCC_DDDD.
- Same-bank conflict:
  - Stimulus: after reset, P0 writes 0x004←1111_2222 and P1 writes 0x008←3333_4444 in the same cycle.
  - Required: P0 granted first, P1 stall=1 for one cycle then acked; readback returns both values.
- Round-robin fairness:
  - Stimulus: P0, P1 and P2 read bank 0 continuously for 9 cycles.
  - Required: grant order 0,1,2,0,1,2,…; each port receives 3 acks and none is starved.
- Byte enables:
  - Stimulus: write 0x010←FFFF_FFFF, then write 0x010←1234_5678 with sel=4'b0101, then read.
  - Required: read returns FF34_FF78.
- Reset mid-operation:
  - Stimulus: assert rst_ni=0 between an accepted read and its ack.
  - Required: ack_o=0 and data_o=0 immediately; after release, a read of a previously written address returns the stored data.
- Pipelined throughput:
  - Stimulus: P2 issues 4 back-to-back reads to bank 1, uncontended.
  - Required: 4 consecutive acks with 1-cycle latency and correct data.
